// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared widths, register-file constants and write-back select encodings
package msrv32_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);
    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t ZERO_REG = 5'd0;
    typedef enum logic [2:0] {
        WB_ALU     = 3'b000,
        WB_LU      = 3'b001,
        WB_IMM     = 3'b010,
        WB_IADDER  = 3'b011,
        WB_CSR     = 3'b100,
        WB_PC_PLUS = 3'b101
    } wb_sel_t;
endpackage

// File: rtl/msrv32_regfile_rd_port.sv
// msrv32_regfile_rd_port: combinational read port with x0 zero-force
// and write-through forwarding when MSRV32_REGFILE_BYPASS_EN is defined.
module msrv32_regfile_rd_port
    import msrv32_pkg::*;
(
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  reg_addr_t                  addr,
`ifdef MSRV32_REGFILE_BYPASS_EN
    input  logic                       wr_q,
    input  reg_addr_t                  wr_addr,
    input  xlen_t                      wr_data,
`endif
    output xlen_t                      data
);
`ifdef MSRV32_REGFILE_BYPASS_EN
    // wr_q already excludes x0, so forwarding can never override the zero read
    assign data = (addr == ZERO_REG) ? '0 : (wr_q && wr_addr == addr) ? wr_data : regs[addr];
`else
    assign data = (addr == ZERO_REG) ? '0 : regs[addr];
`endif
endmodule

// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file: 32x32 integer register file, one sync write, two comb reads.
// Define MSRV32_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module msrv32_integer_file
    import msrv32_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  reg_addr_t rs_1_addr_in,
    input  reg_addr_t rs_2_addr_in,
    input  reg_addr_t rd_addr_in,
    input  xlen_t     rd_in,
    input  logic      wr_en_in,
    input  logic      flush_in,
    output xlen_t     rs_1_out,
    output xlen_t     rs_2_out
);
    logic [NREGS-1:1][XLEN-1:0] reg_file;
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic wr_q;

    assign wr_q = wr_en_in & ~flush_in & (rd_addr_in != ZERO_REG) & ~rst_in;
    // slot 0 is a constant so read ports can index uniformly; it is never stored
    assign regs = {reg_file, {XLEN{1'b0}}};

    always_ff @(posedge clk_in) begin
        if (rst_in)
            reg_file <= '0;
        else if (wr_q)
            reg_file[rd_addr_in] <= rd_in;
    end

    msrv32_regfile_rd_port u_rd_port_1 (
        .regs    (regs),
        .addr    (rs_1_addr_in),
`ifdef MSRV32_REGFILE_BYPASS_EN
        .wr_q    (wr_q),
        .wr_addr (rd_addr_in),
        .wr_data (rd_in),
`endif
        .data    (rs_1_out)
    );

    msrv32_regfile_rd_port u_rd_port_2 (
        .regs    (regs),
        .addr    (rs_2_addr_in),
`ifdef MSRV32_REGFILE_BYPASS_EN
        .wr_q    (wr_q),
        .wr_addr (rd_addr_in),
        .wr_data (rd_in),
`endif
        .data    (rs_2_out)
    );
endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb_msrv32_integer_file: directed literal checks plus randomized traffic
// compared every cycle against an array model of the register file.
module tb_msrv32_integer_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [31:0] rd_d;
    logic        we, fl;
    logic [31:0] rs1, rs2;
    logic [31:0] model [32];
    logic        valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
`ifdef MSRV32_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    msrv32_integer_file dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rs_1_addr_in (rs1_a),
        .rs_2_addr_in (rs2_a),
        .rd_addr_in   (rd_a),
        .rd_in        (rd_d),
        .wr_en_in     (we),
        .flush_in     (fl),
        .rs_1_out     (rs1),
        .rs_2_out     (rs2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        bit commit;
        commit = we && !fl && rd_a != 0 && !rst;
        if (a == 0) return 32'h0;
        if (BYPASS && commit && rd_a == a) return rd_d;
        return model[a];
    endfunction

    // architectural model: reset clears everything, qualified writes land at the edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            valid = 1'b1;
        end else if (we && !fl && rd_a != 0) begin
            model[rd_a] = rd_d;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_rs1", rs1, expect_rd(rs1_a));
            chk("model_rs2", rs2, expect_rd(rs2_a));
        end
    end

    task automatic drv(input logic r, input logic w, input logic f, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        rst = r; we = w; fl = f; rd_a = wa; rd_d = wd; rs1_a = a1; rs2_a = a2;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0);
        step;
        drv(0, 0, 0, 0, 0, 5, 0);
        #2 chk("reset_x5", rs1, 32'h0);
        chk("reset_x0", rs2, 32'h0);
        drv(0, 1, 0, 5, 32'hDEADBEEF, 5, 5);
        step;
        drv(0, 0, 0, 0, 0, 5, 5);
        #2 chk("write_x5", rs1, 32'hDEADBEEF);
        drv(1, 0, 0, 0, 0, 5, 5);
        step;
        drv(0, 0, 0, 0, 0, 5, 5);
        #2 chk("reset_clear_x5", rs1, 32'h0);
        drv(0, 1, 0, 10, 32'h12345678, 0, 0);
        step;
        drv(0, 0, 0, 0, 0, 10, 10);
        #2 chk("basic_rs1", rs1, 32'h12345678);
        chk("basic_rs2", rs2, 32'h12345678);
        drv(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0);
        #2 chk("x0_same_cycle", rs1, 32'h0);
        step;
        drv(0, 0, 0, 0, 0, 0, 0);
        #2 chk("x0_after", rs1, 32'h0);
        drv(0, 1, 1, 3, 32'hA5A5A5A5, 3, 3);
        #2 chk("flush_same_cycle", rs1, 32'h0);
        step;
        drv(0, 0, 0, 0, 0, 3, 3);
        #2 chk("flush_x3", rs1, 32'h0);
        drv(0, 1, 0, 7, 32'h11, 0, 0);
        step;
        drv(0, 1, 0, 7, 32'h22, 0, 7);
        #2 chk("x7_same_cycle", rs2, BYPASS ? 32'h22 : 32'h11);
        step;
        drv(0, 0, 0, 0, 0, 0, 7);
        #2 chk("x7_next", rs2, 32'h22);
        drv(1, 1, 0, 9, 32'h55, 9, 9);
        #2 chk("rst_wr_same_cycle", rs1, 32'h0);
        step;
        drv(0, 0, 0, 0, 0, 9, 9);
        #2 chk("rst_wr_x9", rs1, 32'h0);
        drv(0, 1, 0, 9, 32'h66, 0, 0);
        step;
        drv(0, 0, 0, 0, 0, 9, 9);
        #2 chk("post_rst_write_x9", rs2, 32'h66);
        step;
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), wa, $urandom, a1, a2);
            step;
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
